// File: rtl/tail_light_pkg.sv
// Shared types and constants for the tail-light sequencer: state encoding,
// mode_o codes, lamp ordering and the elaboration-time ramp-level function.
package tail_light_pkg;

  typedef enum logic [2:0] {
    IDLE,
    RUN_L,
    RUN_R,
    RUN_H,
    FADE
  } state_e;

  localparam logic [1:0] MODE_IDLE   = 2'd0;
  localparam logic [1:0] MODE_LEFT   = 2'd1;
  localparam logic [1:0] MODE_RIGHT  = 2'd2;
  localparam logic [1:0] MODE_HAZARD = 2'd3;

  // Lamps are numbered inner-to-outer from each side's innermost lamp.
  localparam int LEFT_INNER  = 3;
  localparam int RIGHT_INNER = 2;

  function automatic int left_lamp(input int pos);
    return LEFT_INNER + pos;
  endfunction

  function automatic int right_lamp(input int pos);
    return RIGHT_INNER - pos;
  endfunction

  // Level k of s, scaled to w bits and saturated to full scale.
  function automatic int ramp_level(input int k, input int s, input int w);
    int full;
    int v;
    full = (1 << w) - 1;
    v    = (k << w) / s;
    return (v > full) ? full : v;
  endfunction

endpackage

// File: rtl/tail_ramp_decode.sv
// Combinational duty decode for one three-lamp side: ramp position, fade
// level or brake override, inner lamp at index 0.
module tail_ramp_decode
  import tail_light_pkg::*;
#(
  parameter int                DUTY_W         = 8,
  parameter int                STEPS_PER_LAMP = 4,
  parameter logic [DUTY_W-1:0] BRAKE_DUTY     = 8'hFF,
  parameter int                STEP_W         = 4,
  parameter int                LVL_W          = 3
) (
  input  logic                   active_i,
  input  logic                   brake_i,
  input  logic                   fade_i,
  input  logic [STEP_W-1:0]      step_i,
  input  logic [LVL_W-1:0]       fade_level_i,
  output logic [2:0][DUTY_W-1:0] duty_o
);

  localparam int S = STEPS_PER_LAMP;
  localparam logic [DUTY_W-1:0] FULL = '1;

  logic [DUTY_W-1:0] ramp_lut [2**LVL_W];

  for (genvar gi = 0; gi < 2**LVL_W; gi++) begin : g_lut
    localparam logic [DUTY_W-1:0] LVL = DUTY_W'(ramp_level(gi, S, DUTY_W));
    assign ramp_lut[gi] = LVL;
  end

  for (genvar gi = 0; gi < 3; gi++) begin : g_lamp
    localparam int LO = gi * S;
    logic [DUTY_W-1:0] lamp_d;

    // Lamps already passed sit at full; the current lamp follows the ramp.
    always_comb begin
      lamp_d = '0;
      if (active_i) begin
        if (fade_i) begin
          lamp_d = ramp_lut[fade_level_i];
        end else if (int'(step_i) >= LO + S) begin
          lamp_d = FULL;
        end else if (int'(step_i) >= LO) begin
          lamp_d = ramp_lut[LVL_W'(int'(step_i) - LO + 1)];
        end
      end else if (brake_i) begin
        lamp_d = BRAKE_DUTY;
      end
    end

    assign duty_o[gi] = lamp_d;
  end

endmodule

// File: rtl/tail_light_sequencer.sv
// Six-lamp tail-light sequencer: arbitrates turn/hazard/brake and drives PWM
// duty words. Define TAIL_FADE_OUT_EN to add a fade-down phase after each run.
module tail_light_sequencer
  import tail_light_pkg::*;
#(
  parameter int                DUTY_W         = 8,
  parameter int                STEPS_PER_LAMP = 4,
  parameter logic [DUTY_W-1:0] BRAKE_DUTY     = 8'hFF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  left_req,
  input  logic                  right_req,
  input  logic                  hazard_req,
  input  logic                  brake_req,
  output logic [6*DUTY_W-1:0]   duty_o,
  output logic                  busy_o,
  output logic [1:0]            mode_o
);

  localparam int S      = STEPS_PER_LAMP;
  localparam int STEP_W = $clog2(3 * S);
  localparam int LVL_W  = $clog2(S + 1);
  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(3 * S - 1);

  state_e            state_q;
  logic [STEP_W-1:0] step_q;
  logic              brake_q;
  logic              left_act_d;
  logic              right_act_d;
  logic              fade_d;
  logic [LVL_W-1:0]  fade_level_d;
  logic [1:0]        mode_d;

`ifdef TAIL_FADE_OUT_EN
  localparam logic [STEP_W-1:0] FADE_LAST = STEP_W'((S > 1) ? S - 2 : 0);
  logic [1:0] fade_mode_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      step_q  <= '0;
      brake_q <= 1'b0;
`ifdef TAIL_FADE_OUT_EN
      fade_mode_q <= MODE_IDLE;
`endif
    end else begin
      brake_q <= brake_req;
      if (tick) begin
        case (state_q)
          IDLE: begin
            step_q <= '0;
            if (hazard_req) begin
              state_q <= RUN_H;
            end else if (left_req ^ right_req) begin
              state_q <= left_req ? RUN_L : RUN_R;
            end
          end
          RUN_L, RUN_R, RUN_H: begin
            // Only a turn run can be preempted; turn requests are ignored here.
            if (state_q != RUN_H && hazard_req) begin
              state_q <= RUN_H;
              step_q  <= '0;
            end else if (step_q == STEP_LAST) begin
              step_q <= '0;
`ifdef TAIL_FADE_OUT_EN
              state_q     <= (S > 1) ? FADE : IDLE;
              fade_mode_q <= mode_d;
`else
              state_q <= IDLE;
`endif
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
`ifdef TAIL_FADE_OUT_EN
          FADE: begin
            if (hazard_req) begin
              state_q <= RUN_H;
              step_q  <= '0;
            end else if (step_q == FADE_LAST) begin
              state_q <= IDLE;
              step_q  <= '0;
            end else begin
              step_q <= step_q + 1'b1;
            end
          end
`endif
          default: begin
            state_q <= IDLE;
            step_q  <= '0;
          end
        endcase
      end
    end
  end

  always_comb begin
    left_act_d  = 1'b0;
    right_act_d = 1'b0;
    mode_d      = MODE_IDLE;
    case (state_q)
      RUN_L: begin
        left_act_d = 1'b1;
        mode_d     = MODE_LEFT;
      end
      RUN_R: begin
        right_act_d = 1'b1;
        mode_d      = MODE_RIGHT;
      end
      RUN_H: begin
        left_act_d  = 1'b1;
        right_act_d = 1'b1;
        mode_d      = MODE_HAZARD;
      end
`ifdef TAIL_FADE_OUT_EN
      FADE: begin
        left_act_d  = (fade_mode_q == MODE_LEFT)  || (fade_mode_q == MODE_HAZARD);
        right_act_d = (fade_mode_q == MODE_RIGHT) || (fade_mode_q == MODE_HAZARD);
        mode_d      = fade_mode_q;
      end
`endif
      default: ;
    endcase
  end

`ifdef TAIL_FADE_OUT_EN
  assign fade_d       = (state_q == FADE);
  assign fade_level_d = LVL_W'(S - 1 - int'(step_q));
`else
  assign fade_d       = 1'b0;
  assign fade_level_d = '0;
`endif

  assign mode_o = mode_d;
  assign busy_o = (state_q != IDLE);

  logic [2:0][DUTY_W-1:0] left_duty;
  logic [2:0][DUTY_W-1:0] right_duty;

  tail_ramp_decode #(
    .DUTY_W(DUTY_W), .STEPS_PER_LAMP(S), .BRAKE_DUTY(BRAKE_DUTY),
    .STEP_W(STEP_W), .LVL_W(LVL_W)
  ) u_left (
    .active_i(left_act_d), .brake_i(brake_q), .fade_i(fade_d),
    .step_i(step_q), .fade_level_i(fade_level_d), .duty_o(left_duty)
  );

  tail_ramp_decode #(
    .DUTY_W(DUTY_W), .STEPS_PER_LAMP(S), .BRAKE_DUTY(BRAKE_DUTY),
    .STEP_W(STEP_W), .LVL_W(LVL_W)
  ) u_right (
    .active_i(right_act_d), .brake_i(brake_q), .fade_i(fade_d),
    .step_i(step_q), .fade_level_i(fade_level_d), .duty_o(right_duty)
  );

  for (genvar gi = 0; gi < 3; gi++) begin : g_map
    localparam int LL = left_lamp(gi);
    localparam int RL = right_lamp(gi);
    assign duty_o[LL*DUTY_W +: DUTY_W] = left_duty[gi];
    assign duty_o[RL*DUTY_W +: DUTY_W] = right_duty[gi];
  end

endmodule

// File: tb/tb_tail_light_sequencer.sv
// Directed self-checking bench for tail_light_sequencer; expected duty words
// are hand-computed for DUTY_W=8, STEPS_PER_LAMP=4, BRAKE_DUTY=8'hFF.
module tb_tail_light_sequencer;

  logic        clk;
  logic        reset;
  logic        tick;
  logic        left_req;
  logic        right_req;
  logic        hazard_req;
  logic        brake_req;
  logic [47:0] duty_o;
  logic        busy_o;
  logic [1:0]  mode_o;

  int n_checks = 0;
  int n_errors = 0;

  // Left-run duty words for steps 0..11 (lamp5..lamp3 in bits 47:24).
  logic [47:0] left_exp [12] = '{
    48'h000040_000000, 48'h000080_000000, 48'h0000C0_000000, 48'h0000FF_000000,
    48'h0040FF_000000, 48'h0080FF_000000, 48'h00C0FF_000000, 48'h00FFFF_000000,
    48'h40FFFF_000000, 48'h80FFFF_000000, 48'hC0FFFF_000000, 48'hFFFFFF_000000
  };

  tail_light_sequencer dut (
    .clk(clk), .reset(reset), .tick(tick),
    .left_req(left_req), .right_req(right_req),
    .hazard_req(hazard_req), .brake_req(brake_req),
    .duty_o(duty_o), .busy_o(busy_o), .mode_o(mode_o)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [47:0] got, input logic [47:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end else begin
      $display("ok   %s: %h", tag, got);
    end
  endtask

  // Called at a negedge; tick is high across exactly one posedge.
  task automatic do_tick();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
  endtask

  task automatic finish_run(input string tag);
    int waited;
    waited = 0;
    while (busy_o && waited < 10) begin
      do_tick();
      waited++;
    end
    check(tag, {47'd0, busy_o}, 48'd0);
  endtask

  initial begin
    reset = 1'b1; tick = 1'b0;
    left_req = 1'b0; right_req = 1'b0; hazard_req = 1'b0; brake_req = 1'b0;
    repeat (2) @(negedge clk);
    check("reset_duty", duty_o, 48'd0);
    check("reset_busy", {47'd0, busy_o}, 48'd0);
    reset = 1'b0;

    repeat (5) do_tick();
    check("idle_duty", duty_o, 48'd0);
    check("idle_busy", {47'd0, busy_o}, 48'd0);
    check("idle_mode", {46'd0, mode_o}, 48'd0);

    // Full left sequence, tick held high back-to-back.
    left_req = 1'b1;
    do_tick();
    left_req = 1'b0;
    check("left_mode", {46'd0, mode_o}, 48'd1);
    check("left_busy", {47'd0, busy_o}, 48'd1);
    check("left_s0", duty_o, left_exp[0]);
    @(negedge clk);
    check("left_hold_no_tick", duty_o, left_exp[0]);
    for (int s = 1; s < 12; s++) begin
      do_tick();
      check($sformatf("left_s%0d", s), duty_o, left_exp[s]);
    end
    do_tick();
`ifdef TAIL_FADE_OUT_EN
    check("fade_c0", duty_o, 48'hC0C0C0_000000);
    check("fade_busy", {47'd0, busy_o}, 48'd1);
    do_tick();
    check("fade_80", duty_o, 48'h808080_000000);
    do_tick();
    check("fade_40", duty_o, 48'h404040_000000);
    do_tick();
`endif
    check("left_end_duty", duty_o, 48'd0);
    check("left_end_busy", {47'd0, busy_o}, 48'd0);

    // Both turn requests together is no request.
    left_req = 1'b1; right_req = 1'b1;
    do_tick();
    check("both_busy", {47'd0, busy_o}, 48'd0);
    check("both_mode", {46'd0, mode_o}, 48'd0);
    left_req = 1'b0;
    do_tick();
    right_req = 1'b0;
    check("right_mode", {46'd0, mode_o}, 48'd2);
    check("right_s0", duty_o, 48'h000000_400000);
    repeat (5) do_tick();
    check("right_s5", duty_o, 48'h000000_FF8000);

    // Hazard preempts the right run and restarts at step 0 on both sides.
    hazard_req = 1'b1;
    do_tick();
    hazard_req = 1'b0;
    check("haz_mode", {46'd0, mode_o}, 48'd3);
    check("haz_s0", duty_o, 48'h000040_400000);
    left_req = 1'b1;
    do_tick();
    left_req = 1'b0;
    check("haz_ignore_turn", {46'd0, mode_o}, 48'd3);
    check("haz_s1", duty_o, 48'h000080_800000);
    brake_req = 1'b1;
    @(negedge clk);
    check("haz_brake_none", duty_o, 48'h000080_800000);
    brake_req = 1'b0;
    repeat (10) do_tick();
    check("haz_s11", duty_o, 48'hFFFFFF_FFFFFF);
    finish_run("haz_done");

    // Brake lights the idle side one clk after the request.
    left_req = 1'b1;
    do_tick();
    left_req = 1'b0;
    repeat (2) do_tick();
    check("brk_pre", duty_o, 48'h0000C0_000000);
    brake_req = 1'b1;
    #1;
    check("brk_latency", duty_o, 48'h0000C0_000000);
    @(negedge clk);
    check("brk_on", duty_o, 48'h0000C0_FFFFFF);
    brake_req = 1'b0;
    @(negedge clk);
    check("brk_off", duty_o, 48'h0000C0_000000);

    // Reset mid-run aborts immediately.
    repeat (5) do_tick();
    check("left_s7", duty_o, left_exp[7]);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("abort_duty", duty_o, 48'd0);
    check("abort_busy", {47'd0, busy_o}, 48'd0);
    check("abort_mode", {46'd0, mode_o}, 48'd0);

    // Brake in IDLE lights all six lamps.
    brake_req = 1'b1;
    @(negedge clk);
    check("idle_brake", duty_o, 48'hFFFFFF_FFFFFF);
    brake_req = 1'b0;
    @(negedge clk);
    check("idle_brake_off", duty_o, 48'd0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
